ps2_action_mapper: RTL and testbench



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_frame_rx.sv | 96 +++++++++
 rtl/ps2_action_mapper.sv | 150 +++++++++++++++
 tb/tb_ps2_action_mapper.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 byte constants, decoder states and event record
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;
  typedef struct packed {
    logic       make;
    logic [3:0] idx;
  } ps2_ev_t;
  // data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronise and filter PS/2 pins, shift in 11-bit frames, check parity/stop, abort stalled frames
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic          r_clk_filt_d;
  logic [FW-1:0] r_filt_cnt;
  logic          r_busy;
  logic [3:0]    r_bit_cnt;
  logic [8:0]    r_shift;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_err;
  logic          w_fall;
  logic          w_bit;
  logic          w_ok;
  assign w_fall       = r_clk_filt_d & ~r_clk_filt;
  assign w_bit        = r_dat_sync[1];
  assign w_ok         = w_bit & odd_parity_ok(r_shift);
  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  // two-flop synchronisers, idle-high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end
  // glitch filter: the clock level flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) r_filt_cnt <= '0;
      else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end
  // frame shifter: start bit opens a frame, bit 10 (stop) closes it; idle edges time out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy       <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_timer      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (!r_busy) begin
        r_timer <= '0;
        if (w_fall && !w_bit) begin
          r_busy    <= 1'b1;
          r_bit_cnt <= 4'd1;
        end
      end else if (w_fall) begin
        r_timer   <= '0;
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (r_bit_cnt == 4'd10) begin
          r_busy       <= 1'b0;
          r_byte       <= r_shift[7:0];
          r_byte_valid <= w_ok;
          r_frame_err  <= ~w_ok;
        end else r_shift <= {w_bit, r_shift[8:1]};
      end else if (r_timer == TW'(TIMEOUT_CYC)) r_busy <= 1'b0;
      else r_timer <= r_timer + TW'(1);
    end
  end
endmodule

// File: rtl/ps2_action_mapper.sv
// ps2_action_mapper: decode PS/2 make/break/E0 sequences into held actions, press pulses and a buffered event stream
module ps2_action_mapper
  import ps2_pkg::*;
#(
  parameter int                         NUM_ACTIONS = 6,
  parameter logic [NUM_ACTIONS*9-1:0]   KEYMAP      = {9'h029, 9'h014, 9'h023, 9'h01C, 9'h01B, 9'h01D},
  parameter int                         FILTER_LEN  = 8,
  parameter int                         TIMEOUT_CYC = 50000,
  parameter int                         FIFO_DEPTH  = 8,
  localparam int                        IW          = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [NUM_ACTIONS-1:0] acoes,
  output logic [NUM_ACTIONS-1:0] press_pulse,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [IW:0]            ev_data,
  output logic                   overflow,
  output logic [7:0]             err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  dec_state_t             r_state;
  dec_state_t             w_state_nx;
  logic [NUM_ACTIONS-1:0] r_acoes;
  logic [NUM_ACTIONS-1:0] r_pulse;
  logic                   r_overflow;
  logic [7:0]             r_err_cnt;
  ps2_ev_t                r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [AW:0]            r_cnt;
  logic [7:0]             w_byte;
  logic                   w_byte_valid;
  logic                   w_frame_err;
  logic                   w_is_code;
  logic                   w_ext;
  logic                   w_brk;
  logic                   w_hit;
  logic [3:0]             w_idx;
  logic [NUM_ACTIONS-1:0] w_onehot;
  logic                   w_held;
  logic                   w_press;
  logic                   w_release;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_wr;
  ps2_ev_t                w_ev;
  ps2_ev_t                w_head;
  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );
  assign w_ext     = (r_state == DEC_EXT) || (r_state == DEC_EXT_BRK);
  assign w_brk     = (r_state == DEC_BRK) || (r_state == DEC_EXT_BRK);
  assign w_onehot  = NUM_ACTIONS'(1) << w_idx;
  assign w_held    = |(r_acoes & w_onehot);
  assign w_press   = w_is_code & w_hit & ~w_brk & ~w_held;
  assign w_release = w_is_code & w_hit & w_brk & w_held;
  assign w_push    = w_press | w_release;
  assign w_ev      = {w_press, w_idx};
  assign w_pop     = ev_valid & ev_ready;
  assign w_full    = r_cnt == (AW + 1)'(FIFO_DEPTH);
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_head    = r_mem[r_rp];
  assign ev_valid  = r_cnt != '0;
  assign ev_data   = {w_head.make, w_head.idx[IW-1:0]};
  assign acoes       = r_acoes;
  assign press_pulse = r_pulse;
  assign overflow    = r_overflow;
  assign err_count   = r_err_cnt;
  // decoder state register; a bad frame drops any pending E0/F0 prefix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= DEC_IDLE;
    else r_state <= w_state_nx;
  end
  // prefix tracking: E0/F0 advance, everything else returns to idle and non-E1/AA bytes are key codes
  always_comb begin
    w_state_nx = r_state;
    w_is_code  = 1'b0;
    if (w_frame_err) w_state_nx = DEC_IDLE;
    else if (w_byte_valid) begin
      if (w_byte == PS2_EXT && r_state == DEC_IDLE) w_state_nx = DEC_EXT;
      else if (w_byte == PS2_BRK && r_state == DEC_IDLE) w_state_nx = DEC_BRK;
      else if (w_byte == PS2_BRK && r_state == DEC_EXT) w_state_nx = DEC_EXT_BRK;
      else begin
        w_state_nx = DEC_IDLE;
        w_is_code  = !(w_byte == PS2_PAUSE || w_byte == PS2_BAT);
      end
    end
  end
  // keymap lookup, scanning downwards so the lowest matching index wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
      if (KEYMAP[i*9 +: 9] == {w_ext, w_byte}) begin
        w_hit = 1'b1;
        w_idx = 4'(i);
      end
    end
  end
  // held vector and press pulses; held state follows keys even when the event is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acoes <= '0;
      r_pulse <= '0;
    end else begin
      r_acoes <= w_press ? (r_acoes | w_onehot) : w_release ? (r_acoes & ~w_onehot) : r_acoes;
      r_pulse <= w_press ? w_onehot : '0;
    end
  end
  // sticky overflow and saturating bad-frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_overflow <= r_overflow | (w_push & w_full & ~w_pop);
      r_err_cnt  <= (w_frame_err && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
    end
  end
  // FIFO pointers and occupancy; push while full is accepted only alongside a pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_wr ? r_wp + AW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
      r_cnt <= r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
    end
  end
  // FIFO storage needs no reset: occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= w_ev;
  end
endmodule

// File: tb/tb_ps2_action_mapper.sv
// tb_ps2_action_mapper: randomized PS/2 stimulus with keyboard-level reference model and event scoreboard
module tb_ps2_action_mapper;
  localparam int NA      = 6;
  localparam int DEPTH   = 8;
  localparam int FILT    = 8;
  localparam int TMO     = 1000;
  localparam int HALF    = 20;
  localparam int GAP     = 40;
  localparam logic [NA*9-1:0] KM = {9'h175, 9'h014, 9'h023, 9'h01C, 9'h01B, 9'h01D};
  logic          clk;
  logic          reset;
  logic          ps2_clk;
  logic          ps2_data;
  logic [NA-1:0] acoes;
  logic [NA-1:0] press_pulse;
  logic          ev_valid;
  logic          ev_ready;
  logic [3:0]    ev_data;
  logic          overflow;
  logic [7:0]    err_count;
  ps2_action_mapper #(
    .NUM_ACTIONS(NA),
    .KEYMAP     (KM),
    .FILTER_LEN (FILT),
    .TIMEOUT_CYC(TMO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .acoes      (acoes),
    .press_pulse(press_pulse),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data),
    .overflow   (overflow),
    .err_count  (err_count)
  );
  // keyboard-level model: which physical key (ext flag + code) drives each action
  logic [8:0]    keys [NA] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h014, 9'h175};
  logic [7:0]    pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h14, 8'h75, 8'h29, 8'h12};
  logic [3:0]    exp_q [$];
  bit            pend_ext;
  bit            pend_brk;
  logic [NA-1:0] held;
  int            exp_pulse [NA];
  int            pulse_cnt [NA];
  int            exp_err;
  bit            exp_ovf;
  int            errors;
  int            checks;
  int            rdy_mode;
  logic [3:0]    got_ev;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // ev_ready: 0 = held low, 1 = held high, 2 = random each cycle
  initial begin
    ev_ready = 0;
    forever begin
      @(posedge clk);
      #2 ev_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end
  // monitor: pops the scoreboard on every accepted event and tallies press pulses
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NA; i++) pulse_cnt[i] += int'(press_pulse[i]);
      if (ev_valid && ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ev_unexpected: got %h, expected no event", ev_data);
        end else begin
          got_ev = exp_q.pop_front();
          if (ev_data !== got_ev) begin
            errors++;
            $display("FAIL ev_data: got %h, expected %h", ev_data, got_ev);
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_push(input bit mk, input int i);
    if (exp_q.size() >= DEPTH) exp_ovf = 1;
    else exp_q.push_back({mk, 3'(i)});
  endtask
  // what a keyboard host should conclude from one received byte
  task automatic model_byte(input logic [7:0] b, input bit bad);
    int hit;
    bit brk;
    if (bad) begin
      exp_err  = (exp_err < 255) ? exp_err + 1 : 255;
      pend_ext = 0;
      pend_brk = 0;
      return;
    end
    if (b == 8'hE0 && !pend_ext && !pend_brk) begin
      pend_ext = 1;
      return;
    end
    if (b == 8'hF0 && !pend_brk) begin
      pend_brk = 1;
      return;
    end
    brk = pend_brk;
    hit = -1;
    if (b != 8'hE1 && b != 8'hAA)
      for (int i = NA - 1; i >= 0; i--) if (keys[i] == {pend_ext, b}) hit = i;
    pend_ext = 0;
    pend_brk = 0;
    if (hit < 0) return;
    if (!brk && !held[hit]) begin
      held[hit] = 1;
      exp_pulse[hit]++;
      model_push(1, hit);
    end else if (brk && held[hit]) begin
      held[hit] = 0;
      model_push(0, hit);
    end
  endtask
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      ps2_data = f[k];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 0;
      if (k == 10) model_byte(b, bad);
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1;
    end
    repeat (GAP) @(posedge clk);
  endtask
  task automatic key(input logic [8:0] k, input bit brk);
    if (k[8]) send_frame(8'hE0, 0);
    if (brk) send_frame(8'hF0, 0);
    send_frame(k[7:0], 0);
  endtask
  task automatic check_state(input string tag);
    chk({tag, ".acoes"}, 32'(acoes), 32'(held));
    chk({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    for (int i = 0; i < NA; i++) chk($sformatf("%s.pulses%0d", tag, i), 32'(pulse_cnt[i]), 32'(exp_pulse[i]));
  endtask
  task automatic drain(input string tag);
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    chk({tag, ".drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask
  task automatic model_clear();
    exp_q.delete();
    pend_ext = 0;
    pend_brk = 0;
    held     = '0;
    exp_err  = 0;
    exp_ovf  = 0;
    for (int i = 0; i < NA; i++) begin
      exp_pulse[i] = 0;
      pulse_cnt[i] = 0;
    end
  endtask
  task automatic do_reset();
    ps2_clk  = 1;
    ps2_data = 1;
    reset    = 1;
    repeat (3) @(posedge clk);
    #1 model_clear();
    reset = 0;
    repeat (5) @(posedge clk);
  endtask
  initial begin
    errors   = 0;
    checks   = 0;
    rdy_mode = 1;
    ps2_clk  = 1;
    ps2_data = 1;
    reset    = 1;
    model_clear();
    repeat (4) @(posedge clk);
    #1;
    chk("rst.acoes", 32'(acoes), 0);
    chk("rst.press_pulse", 32'(press_pulse), 0);
    chk("rst.ev_valid", 32'(ev_valid), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.err_count", 32'(err_count), 0);
    reset = 0;
    repeat (5) @(posedge clk);
    // make then break of W
    send_frame(8'h1D, 0);
    check_state("make_w");
    key(9'h01D, 1);
    check_state("break_w");
    // typematic repeats
    repeat (3) send_frame(8'h1D, 0);
    check_state("typematic");
    key(9'h01D, 1);
    // extended key: plain 75 is unmapped, E0 75 is mapped
    send_frame(8'h75, 0);
    check_state("plain75");
    key(9'h175, 0);
    check_state("ext75_make");
    key(9'h175, 1);
    check_state("ext75_break");
    // parity error, then bad frame clearing a pending F0
    send_frame(8'h1D, 1);
    check_state("bad_parity");
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 1);
    send_frame(8'h1D, 0);
    check_state("prefix_cleared");
    key(9'h01D, 1);
    drain("directed");
    // random byte stream with random consumer back-pressure
    rdy_mode = 2;
    for (int n = 0; n < 50; n++) begin
      send_frame(pool[$urandom_range(0, 11)], $urandom_range(0, 9) == 0);
      if (n % 10 == 9) check_state($sformatf("rand%0d", n));
    end
    rdy_mode = 1;
    send_frame(8'hAA, 0);
    for (int i = 0; i < NA; i++) if (held[i]) key(keys[i], 1);
    check_state("released");
    drain("random");
    // overflow: nine events into an eight-deep FIFO with the consumer stalled
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) key(keys[i], 0);
    for (int i = 0; i < 4; i++) key(keys[i], 1);
    key(keys[4], 0);
    check_state("overflow");
    chk("overflow.ev_valid", 32'(ev_valid), 1);
    chk("overflow.queued", 32'(exp_q.size()), DEPTH);
    rdy_mode = 1;
    drain("overflow");
    // abandoned frame times out silently
    do_reset();
    ps2_bit(1'b0);
    for (int k = 0; k < 4; k++) ps2_bit(1'b1);
    repeat (TMO + FILT + 50) @(posedge clk);
    send_frame(8'h1C, 0);
    check_state("timeout");
    drain("timeout");
    // asynchronous reset mid-frame clears everything at once
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    send_frame(8'h1B, 0);
    send_frame(8'h23, 1);
    chk("pre_rst.ev_valid", 32'(ev_valid), 1);
    chk("pre_rst.err_count", 32'(err_count), 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("midrst.acoes", 32'(acoes), 0);
    chk("midrst.ev_valid", 32'(ev_valid), 0);
    chk("midrst.err_count", 32'(err_count), 0);
    chk("midrst.overflow", 32'(overflow), 0);
    chk("midrst.press_pulse", 32'(press_pulse), 0);
    do_reset();
    rdy_mode = 1;
    send_frame(8'h1D, 0);
    check_state("after_rst");
    drain("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
